// File: rtl/iobus_master.sv
// Bus initiator for the 8-register I/O peripheral bus: byte-stream commands in, read bytes out.
// Optional IRQ auto-acknowledge read of address 4 is built when IOBUS_IRQ_AUTOACK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for header byte or pending IRQ
// WDATA   | waiting for next write-data byte
// WISSUE  | write cycle on the bus (cs=1, rw=0)
// RISSUE  | read cycle on the bus (cs=1, rw=1)
// RWAIT   | waiting RD_WAIT cycles for peripheral read data
// RSEND   | response held until rsp_ready
module iobus_master #(
  parameter int RD_WAIT = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_irq,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       bus_cs,
  output logic       bus_rw,
  output logic [2:0] bus_ad,
  output logic [7:0] bus_do,
  input  logic [7:0] bus_di,
  input  logic       irq,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_WISSUE, S_RISSUE, S_RWAIT, S_RSEND
  } state_t;

  localparam logic [2:0] LP_WAIT_LD = 3'(RD_WAIT - 1);
  localparam logic [2:0] LP_IRQ_ADDR = 3'd4;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_addr;
  logic [2:0] r_rem;
  logic [2:0] r_wait;
  logic       r_fixed;
  logic       r_irq_op;
  logic [7:0] r_do;
  logic [7:0] r_rsp_data;
  logic       w_irq_pend;
  logic       w_hdr_fire;
  logic       w_irq_start;
  logic       w_data_fire;
  logic       w_capture;
  logic       w_next_xfer;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_fire  = 1'b0;
    w_irq_start = 1'b0;
    w_data_fire = 1'b0;
    w_capture   = 1'b0;
    w_next_xfer = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_irq_pend) begin
          w_irq_start = 1'b1;
          w_state_nxt = S_RISSUE;
        end else if (cmd_valid) begin
          w_hdr_fire  = 1'b1;
          w_state_nxt = cmd_data[7] ? S_RISSUE : S_WDATA;
        end
      end
      S_WDATA: begin
        if (cmd_valid) begin
          w_data_fire = 1'b1;
          w_state_nxt = S_WISSUE;
        end
      end
      S_WISSUE: begin
        if (r_rem != 3'd0) begin
          w_next_xfer = 1'b1;
          w_state_nxt = S_WDATA;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RISSUE: w_state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (r_wait == 3'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RSEND;
        end
      end
      S_RSEND: begin
        if (rsp_ready) begin
          if (r_rem != 3'd0) begin
            w_next_xfer = 1'b1;
            w_state_nxt = S_RISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_addr     <= 3'd0;
      r_rem      <= 3'd0;
      r_wait     <= 3'd0;
      r_fixed    <= 1'b0;
      r_irq_op   <= 1'b0;
      r_do       <= 8'd0;
      r_rsp_data <= 8'd0;
    end else begin
      if (w_hdr_fire) begin
        r_addr   <= cmd_data[2:0];
        r_rem    <= cmd_data[5:3];
        r_fixed  <= cmd_data[6];
        r_irq_op <= 1'b0;
      end
      if (w_irq_start) begin
        r_addr   <= LP_IRQ_ADDR;
        r_rem    <= 3'd0;
        r_fixed  <= 1'b1;
        r_irq_op <= 1'b1;
      end
      if (w_data_fire) r_do <= cmd_data;
      if (w_next_xfer) begin
        r_rem <= r_rem - 3'd1;
        if (!r_fixed) r_addr <= r_addr + 3'd1;
      end
      if (r_state == S_RISSUE)                      r_wait <= LP_WAIT_LD;
      else if (r_state == S_RWAIT && r_wait != 3'd0) r_wait <= r_wait - 3'd1;
      if (w_capture) r_rsp_data <= bus_di;
    end
  end

`ifdef IOBUS_IRQ_AUTOACK_EN
  logic r_irq_q;
  logic r_irq_pend;
  logic r_rsp_irq;

  // Pending flag survives a burst; cleared by the auto-ack cs itself.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_irq_q    <= 1'b0;
      r_irq_pend <= 1'b0;
      r_rsp_irq  <= 1'b0;
    end else begin
      r_irq_q    <= irq;
      r_irq_pend <= (irq & ~r_irq_q) |
                    (r_irq_pend & ~((r_state == S_RISSUE) & r_irq_op));
      if (w_capture) r_rsp_irq <= r_irq_op;
    end
  end

  assign w_irq_pend = r_irq_pend;
  assign rsp_irq    = r_rsp_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign w_irq_pend   = 1'b0;
  assign rsp_irq      = 1'b0;
`endif

  assign cmd_ready = ~rst & (((r_state == S_IDLE) & ~w_irq_pend) | (r_state == S_WDATA));
  assign bus_cs    = (r_state == S_WISSUE) | (r_state == S_RISSUE);
  assign bus_rw    = (r_state != S_WISSUE);
  assign bus_ad    = r_addr;
  assign bus_do    = r_do;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = (r_state == S_RSEND);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_iobus_master.sv
// Self-checking bench for iobus_master: scoreboard of expected bus cycles and responses.
// Expectations follow IOBUS_IRQ_AUTOACK_EN when the bench is built with it defined.
module tb_iobus_master;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_irq;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       bus_cs;
  logic       bus_rw;
  logic [2:0] bus_ad;
  logic [7:0] bus_do;
  logic [7:0] bus_di;
  logic       irq;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {logic rw; logic [2:0] ad; logic [7:0] dout;} cs_t;
  typedef struct {logic [7:0] d; logic irq;} rsp_t;

  cs_t  cs_q[$];
  rsp_t rsp_q[$];

  logic [7:0] periph [8];
  logic [7:0] exp_regs [8];
  bit         p_init;

  iobus_master dut (
    .clk_in(clk_in), .rst(rst),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_irq(rsp_irq), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .bus_cs(bus_cs), .bus_rw(bus_rw), .bus_ad(bus_ad), .bus_do(bus_do), .bus_di(bus_di),
    .irq(irq), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] init_val(int i);
    return 8'(8'h31 * i + 8'h07);
  endfunction

  // Peripheral stand-in: registers read data at the cs edge, DO valid the next cycle.
  always @(posedge clk_in) begin
    if (!p_init) begin
      for (int i = 0; i < 8; i++) periph[i] <= init_val(i);
      p_init <= 1'b1;
    end else if (bus_cs === 1'b1) begin
      if (bus_rw) bus_di <= periph[bus_ad];
      else        periph[bus_ad] <= bus_do;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk_in) begin
    #1;
    if (bus_cs === 1'b1) begin
      chk("cs_expected", 32'(cs_q.size() != 0), 1);
      if (cs_q.size() != 0) begin
        cs_t e;
        e = cs_q.pop_front();
        chk("cs_rw", bus_rw, e.rw);
        chk("cs_ad", bus_ad, e.ad);
        if (!e.rw) chk("cs_do", bus_do, e.dout);
      end
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      chk("rsp_expected", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_data", rsp_data, r.d);
        chk("rsp_irq", rsp_irq, r.irq);
      end
    end
  end

  task automatic push_wr(input logic [2:0] ad, input logic [7:0] d);
    cs_q.push_back('{rw: 1'b0, ad: ad, dout: d});
    exp_regs[ad] = d;
  endtask

  task automatic push_rd(input logic [2:0] ad, input logic irqf);
    cs_q.push_back('{rw: 1'b1, ad: ad, dout: 8'h00});
    rsp_q.push_back('{d: exp_regs[ad], irq: irqf});
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    chk("cmd_accept_timeout", 32'(n < 50), 1);
    @(negedge clk_in);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("idle_timeout", 32'(n < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_data  = 8'h00;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    irq       = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = init_val(i);
    repeat (3) @(negedge clk_in);

    chk("rst_bus_cs", bus_cs, 0);
    chk("rst_bus_rw", bus_rw, 1);
    chk("rst_bus_ad", bus_ad, 0);
    chk("rst_bus_do", bus_do, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_irq", rsp_irq, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk_in);
    chk("idle_cmd_ready", cmd_ready, 1);

    // Single write: cs in cycle 2, idle in cycle 3
    push_wr(3'd0, 8'h5A);
    send_byte(8'h00);
    chk("w1_busy", busy, 1);
    chk("w1_cs_c1", bus_cs, 0);
    send_byte(8'h5A);
    chk("w1_cs_c2", bus_cs, 1);
    chk("w1_rw_c2", bus_rw, 0);
    chk("w1_do_c2", bus_do, 8'h5A);
    @(negedge clk_in);
    chk("w1_cs_c3", bus_cs, 0);
    chk("w1_busy_c3", busy, 0);

    // Incrementing read burst wrapping 7 -> 0
    push_rd(3'd6, 1'b0);
    push_rd(3'd7, 1'b0);
    push_rd(3'd0, 1'b0);
    push_rd(3'd1, 1'b0);
    send_byte(8'h9E);
    chk("r4_cs_c1", bus_cs, 1);
    chk("r4_ad_c1", bus_ad, 6);
    wait_idle();
    chk("r4_cs_left", cs_q.size(), 0);
    chk("r4_rsp_left", rsp_q.size(), 0);

    // Back-pressured single read
    rsp_ready = 1'b0;
    push_rd(3'd4, 1'b0);
    send_byte(8'h84);
    chk("bp_cs_c1", bus_cs, 1);
    @(negedge clk_in);
    chk("bp_valid_c2", rsp_valid, 0);
    @(negedge clk_in);
    chk("bp_valid_c3", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_data", rsp_data, exp_regs[4]);
      chk("bp_hold_cs", bus_cs, 0);
      @(negedge clk_in);
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_rsp_left", rsp_q.size(), 0);

    // Fixed-address write burst at one write per two cycles
    push_wr(3'd2, 8'h11);
    push_wr(3'd2, 8'h22);
    send_byte(8'h4A);
    send_byte(8'h11);
    chk("fw_cs1", bus_cs, 1);
    send_byte(8'h22);
    chk("fw_cs2", bus_cs, 1);
    chk("fw_ad2", bus_ad, 2);
    chk("fw_do2", bus_do, 8'h22);
    wait_idle();
    push_rd(3'd2, 1'b0);
    send_byte(8'h82);
    wait_idle();
    chk("fw_cs_left", cs_q.size(), 0);
    chk("fw_rsp_left", rsp_q.size(), 0);

    // IRQ edge arriving during a 2-read burst
    push_rd(3'd0, 1'b0);
    push_rd(3'd1, 1'b0);
`ifdef IOBUS_IRQ_AUTOACK_EN
    push_rd(3'd4, 1'b1);
`endif
    send_byte(8'h88);
    @(negedge clk_in);
    irq = 1'b1;
    wait_idle();
`ifdef IOBUS_IRQ_AUTOACK_EN
    chk("irq_cmd_ready_pend", cmd_ready, 0);
    @(negedge clk_in);
    chk("irq_busy", busy, 1);
    wait_idle();
`else
    chk("irq_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge clk_in);
`endif
    irq = 1'b0;
    chk("irq_cs_left", cs_q.size(), 0);
    chk("irq_rsp_left", rsp_q.size(), 0);

    // Reset during RWAIT of a 3-read burst
    cs_q.push_back('{rw: 1'b1, ad: 3'd5, dout: 8'h00});
    send_byte(8'h95);
    chk("rr_cs_c1", bus_cs, 1);
    @(negedge clk_in);
    chk("rr_busy_rwait", busy, 1);
    rst = 1'b1;
    #1;
    chk("rr_cs_async", bus_cs, 0);
    chk("rr_valid_async", rsp_valid, 0);
    chk("rr_busy_async", busy, 0);
    chk("rr_ready_async", cmd_ready, 0);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    chk("rr_ready_after", cmd_ready, 1);
    chk("rr_cs_left0", cs_q.size(), 0);
    push_rd(3'd3, 1'b0);
    send_byte(8'h83);
    chk("rr_ad_c1", bus_ad, 3);
    wait_idle();
    repeat (3) @(negedge clk_in);
    chk("rr_cs_left", cs_q.size(), 0);
    chk("rr_rsp_left", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
